// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame reader stream path.
//   FRAME_PIXELS : default pixels per frame (H_DISPLAY * V_DISPLAY)
//   state_e      : frame reader FSM states
//   tag_t        : per-read sideband carried alongside an outstanding memory read
`ifndef H_DISPLAY
`define H_DISPLAY 640
`endif
`ifndef V_DISPLAY
`define V_DISPLAY 480
`endif

package vga_pkg;

  localparam int FRAME_PIXELS = `H_DISPLAY * `V_DISPLAY;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/vga_sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the head entry.
// A pop on empty is ignored; a push on full is accepted only when a pop
// frees the slot in the same cycle.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset (pointers/count only)
//   push, wdata        : write side
//   pop, rdata         : read side (rdata = head entry)
//   empty, full, count : occupancy status
module vga_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_FULL);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rdata     = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Sweeps a frame buffer in system memory one pixel per read and streams
// {frame_start, rgb} words to the VGA line buffer.
// Ports:
//   sys_clk, sys_rst_n          : clock, async active-low reset
//   enable                      : stream continuously; dropping it ends after the current frame
//   base_addr                   : frame base, captured when pixel 0 is accepted
//   mem_rd, mem_addr, mem_rdy   : read request handshake
//   mem_rdata                   : read data, RD_LATENCY cycles after accept
//   line_buffer_data/vld/rdy    : output stream {frame_start, rgb}
//   busy                        : FSM not idle
//   frame_done                  : pulse when the last pixel of a frame leaves
//
// state | meaning
// IDLE  | no reads issued, waiting for enable
// READ  | issuing reads while credits remain
// DRAIN | frame fully requested, waiting for in-flight data and FIFO to empty
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int RGB_SIZE     = 12,
  parameter int AW           = 19,
  parameter int RD_LATENCY   = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                enable,
  input  logic [AW-1:0]       base_addr,
  output logic                mem_rd,
  output logic [AW-1:0]       mem_addr,
  input  logic                mem_rdy,
  input  logic [RGB_SIZE-1:0] mem_rdata,
  output logic [RGB_SIZE:0]   line_buffer_data,
  output logic                line_buffer_vld,
  input  logic                line_buffer_rdy,
  output logic                busy,
  output logic                frame_done
);

  localparam int PCW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PCW-1:0] LAST_PIX = PCW'(FRAME_PIXELS - 1);
  localparam logic [PCW-1:0] PIX_ONE  = PCW'(1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [PCW-1:0]        r_pix_cnt;
  logic [AW-1:0]         r_base_lat;
  logic [AW-1:0]         w_addr;
  tag_t                  r_tag [RD_LATENCY];
  tag_t                  w_tag_in;
  tag_t                  w_tail;
  logic [CW-1:0]         r_inflight;
  logic [CW-1:0]         w_fifo_count;
  logic [CW-1:0]         w_credits;
  logic                  w_accept;
  logic                  w_first;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic [RGB_SIZE+1:0]   w_fifo_wdata;
  logic [RGB_SIZE+1:0]   w_fifo_rdata;

  assign w_first  = (r_pix_cnt == '0);
  assign w_last   = (r_pix_cnt == LAST_PIX);
  assign w_accept = mem_rd & mem_rdy;
  // Pixel 0 must use the live base so a new frame picks up base_addr without a bubble.
  assign w_addr   = w_first ? base_addr : (r_base_lat + AW'(r_pix_cnt));

  // Every accepted read owns a FIFO slot until it is popped, so the FIFO cannot overflow.
  assign w_credits = CNT_FULL - w_fifo_count - r_inflight;

  // ---------------- FSM ----------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = READ;
      READ:    if (w_accept && w_last && !enable) w_state_nxt = DRAIN;
      DRAIN:   if (r_inflight == '0 && w_empty) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    busy     = (r_state != IDLE);
    // !w_full is implied by credits > 0; kept as a cheap safety net.
    if (r_state == READ && w_credits != '0 && !w_full) begin
      mem_rd   = 1'b1;
      mem_addr = w_addr;
    end
  end

  // ---------------- pixel counter / base latch / in-flight tracking ----------------
  assign w_tag_in = '{vld: w_accept, first: w_first, last: w_last};
  assign w_tail   = r_tag[RD_LATENCY-1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pix_cnt  <= '0;
      r_base_lat <= '0;
      r_inflight <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      if (w_accept) begin
        r_pix_cnt <= w_last ? '0 : (r_pix_cnt + PIX_ONE);
        if (w_first) r_base_lat <= base_addr;
      end
      case ({w_accept, w_tail.vld})
        2'b10:   r_inflight <= r_inflight + CNT_ONE;
        2'b01:   r_inflight <= r_inflight - CNT_ONE;
        default: r_inflight <= r_inflight;
      endcase
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // ---------------- output FIFO ----------------
  assign w_fifo_wdata = {w_tail.last, w_tail.first, mem_rdata};

  vga_sync_fifo #(
    .WIDTH (RGB_SIZE + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (w_tail.vld),
    .pop       (w_pop),
    .wdata     (w_fifo_wdata),
    .rdata     (w_fifo_rdata),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_fifo_count)
  );

  assign line_buffer_vld  = ~w_empty;
  assign w_pop            = line_buffer_vld & line_buffer_rdy;
  // Masked so stale FIFO storage never shows on the bus while empty.
  assign line_buffer_data = line_buffer_vld ? w_fifo_rdata[RGB_SIZE:0] : '0;
  assign frame_done       = w_pop & w_fifo_rdata[RGB_SIZE+1];

endmodule
